uart_tx_peri: RTL
=================

# uart_tx_peri

Memory-mapped UART transmitter peripheral for the single-cycle RISC-V microcontroller. It consumes the core's peripheral store and load bus (ALU-result address, RD2 write data, qualified write enable) and serialises bytes as 8N1 frames on a single output pin. A small transmit FIFO lets firmware queue several bytes without polling between stores. Reads are combinational so single-cycle loads return status in the same cycle.

## Interface
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, 2..16
- BAUD_DIV_RESET, 868, reset value of BAUDDIV in clock cycles per bit (100 MHz / 115200)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- A  in  5  byte address within peripheral window (ALU result [4:0]); bits [1:0] ignored
- WD  in  32  store data (register RD2)
- WE  in  1  store strobe, already qualified by peripheral select and MemWrite
- RD  out  32  combinational read data for address A
- tx  out  1  serial output, idle high

## Operation
- Register map (word offsets):
  - 0x00 TXDATA: write pushes WD[7:0] into FIFO; read returns 0
  - 0x04 STATUS: read {16'b0, count[7:0], 4'b0, ovf, empty, full, busy}; write with WD[3]=1 clears ovf
  - 0x08 BAUDDIV: read {16'b0, div[15:0]}; write loads WD[15:0], values <2 stored as 2
  - other offsets: read 0, writes ignored
- busy = FIFO non-empty OR FSM not IDLE; full = count==FIFO_DEPTH; empty = count==0
- Push when full is dropped; sets ovf (sticky). A push is dropped whenever full is asserted before the edge, even if the FSM pops in the same cycle.
- FSM states: IDLE, START, DATA, STOP
  - IDLE: tx=1; if FIFO non-empty, pop head into shift reg, latch div into bit_len, cnt<=0, tx<=0, go START
  - START: hold tx=0 for bit_len cycles, then tx<=shift[0], bit index 0, go DATA
  - DATA: each bit lasts bit_len cycles, LSB first; after bit 7, tx<=1, go STOP
  - STOP: hold tx=1 for bit_len cycles; at end, if FIFO non-empty pop and go directly to START (tx<=0), else go IDLE
- BAUDDIV writes mid-frame do not affect the current frame; the new value applies from the next start bit.
- Counter cnt is 16 bit, runs 0..bit_len-1, and wraps at each bit boundary.
- FIFO is a circular buffer with log2(FIFO_DEPTH)-bit pointers that wrap modulo depth, and a separate count.

## Timing
- Reset values: tx=1, FSM=IDLE, count=0, pointers=0, ovf=0, div=BAUD_DIV_RESET. RD depends only on A and state (STATUS reads 0x0000_0004 after reset).
- rst mid-frame: at the next edge, tx=1 and all state returns to reset values; queued bytes are discarded.
- Write on edge E into an idle, empty block: count=1 after E; tx falls at edge E+1.
- Frame length is exactly 10*bit_len cycles. Back-to-back frames have no idle cycle between the stop bit and the next start bit.
- A STATUS write clearing ovf on the same edge as an overflowing push leaves ovf=1 (set wins).
- RD is valid in the same cycle A is presented; it reflects register state before the current edge.

## Test plan
- Reset, div=4, store 0x55 to 0x00 -> tx low at E+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high for 4 cycles; busy=0 at 40 cycles after E+1.
- Store 0x41, 0x42 back-to-back (div=2) -> two frames of 20 cycles each, no gap, LSB-first bytes match; empty asserted after the second pop.
- Store 6 bytes while the FIFO (depth 4) is idle-draining with a slow div=1000 -> 1 byte in the shifter plus 4 queued; the sixth push is dropped and STATUS reads ovf=1, full=1, count=4. A STATUS write of 0x8 clears ovf.
- Write BAUDDIV=0 -> reads back 2. Write BAUDDIV=8 mid-frame at div=2 -> current frame keeps 2-cycle bits; next frame uses 8.
- Assert rst during DATA bit 3 -> tx=1 at the next edge, STATUS=0x4, BAUDDIV=868, and no further frames are sent.
- Read offsets 0x00, 0x0C, 0x1C -> RD=0; writes to them do not change STATUS or BAUDDIV.

Source files
------------

// File: rtl/uart_tx_peri.sv
// 8N1 UART transmitter on the core peripheral bus, fed by a small transmit FIFO; RD is combinational.
// Latency: tx falls one cycle after a store to an idle block; no backpressure, stores into a full FIFO are dropped and set ovf.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module uart_tx_peri #(
    parameter int FIFO_DEPTH     = 4,
    parameter int BAUD_DIV_RESET = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        tx
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [15:0]   div;
    logic [15:0]   bit_len;
    logic [15:0]   cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          ovf;
    logic [7:0]    head_dat;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          busy;
    logic          sel_data;
    logic          sel_stat;
    logic          sel_div;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          unused_bits;

    assign unused_bits = ^{WD[31:16], A[1:0]};

    assign sel_data = A[4:2] == 3'd0;
    assign sel_stat = A[4:2] == 3'd1;
    assign sel_div  = A[4:2] == 3'd2;
    assign push     = WE && sel_data;
    assign bit_end  = cnt == bit_len - 16'd1;
    // The FIFO is popped either from IDLE or straight out of a finishing stop bit.
    assign pop      = ((state == IDLE) || ((state == STOP) && bit_end)) && !empty;
    assign busy     = !empty || (state != IDLE);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (WD[7:0]),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        RD = '0;
        case (A[4:2])
            3'd1:    RD = {16'b0, 8'(count), 4'b0, ovf, empty, full, busy};
            3'd2:    RD = {16'b0, div};
            default: RD = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            ovf     <= 1'b0;
            div     <= 16'(BAUD_DIV_RESET);
            bit_len <= 16'(BAUD_DIV_RESET);
            cnt     <= '0;
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            // An overflowing push wins over a simultaneous clear.
            if (push && full)                 ovf <= 1'b1;
            else if (WE && sel_stat && WD[3]) ovf <= 1'b0;

            if (WE && sel_div) div <= (WD[15:0] < 16'd2) ? 16'd2 : WD[15:0];

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= head_dat;
                        bit_len <= div;
                        cnt     <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= shift[bit_idx + 3'd1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (pop) begin
                            shift   <= head_dat;
                            bit_len <= div;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
